snn_maxpool1d: RTL and testbench

Event-driven 1D spike max-pooling layer for the SNN accelerator pipeline. It collects input spike events for one frame, each tagged with channel, position and timestamp, into per-channel pooling windows. Each window keeps only its latest (maximum) timestamp. At end of frame it streams one output spike per occupied window and raises layer_done.

---
 rtl/snn_maxpool1d.sv | 201 ++++++++++++++++++++
 tb/tb_snn_maxpool1d.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_maxpool1d.sv
// Event-driven 1D spike max-pooling layer: gathers one frame of spikes into per-channel
// windows (latest timestamp wins) and streams one spike per occupied window at end of frame.
// Optional drop counter port/logic: define SNN_MAXPOOL1D_DROP_CNT_EN.
module snn_maxpool1d #(
  parameter int INPUT_LENGTH    = 16,
  parameter int INPUT_CHANNELS  = 4,
  parameter int POOL_SIZE       = 2,
  parameter int STRIDE          = 2,
  parameter int OUTPUT_LENGTH   = INPUT_LENGTH / STRIDE,
  parameter int VMEM_WIDTH      = 16,
  parameter int TIMESTAMP_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        s_axis_input_tvalid,
  input  logic [31:0] s_axis_input_tdata,
  input  logic        s_axis_input_tlast,
  output logic        s_axis_input_tready,
  output logic        m_axis_output_tvalid,
  output logic [31:0] m_axis_output_tdata,
  output logic        m_axis_output_tlast,
  input  logic        m_axis_output_tready,
  input  logic        config_valid,
  input  logic [31:0] config_data,
  output logic        busy,
  output logic        layer_done
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
  ,
  output logic [15:0] drop_count
`endif
);

  localparam int NUM_WIN = INPUT_CHANNELS * OUTPUT_LENGTH;
  localparam int IDX_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int CH_W    = (INPUT_CHANNELS > 1) ? $clog2(INPUT_CHANNELS) : 1;
  localparam int POS_W   = (OUTPUT_LENGTH > 1) ? $clog2(OUTPUT_LENGTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    EMIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0] in_pos, in_ch, in_ts, in_flag;
  assign {in_pos, in_ch, in_ts, in_flag} = s_axis_input_tdata;

  logic                     start;
  logic                     accept_hs;
  logic                     spike_ok;
  logic [OUTPUT_LENGTH-1:0] win_hit;
  logic [NUM_WIN-1:0]       occ;
  logic [NUM_WIN-1:0]       upd;
  // Upper timestamp bits are always zero, so only the low byte is kept.
  logic [7:0]               ts_mem [NUM_WIN];

  logic [IDX_W-1:0] scan_idx;
  logic [CH_W-1:0]  scan_ch;
  logic [POS_W-1:0] scan_pos;
  logic             cur_occ;
  logic             later_occ;
  logic             scan_step;
  logic             scan_end;

  // Parameters and fields that exist only for interface uniformity.
  logic unused_bits;
  assign unused_bits = ^{in_flag[7:1], config_data[31:1], VMEM_WIDTH[0], TIMESTAMP_WIDTH[0]};

  assign start     = enable && config_valid && config_data[0] && (state == IDLE || state == DONE);
  assign accept_hs = enable && (state == ACCEPT) && s_axis_input_tvalid;
  assign spike_ok  = in_flag[0] && (32'(in_ch) < INPUT_CHANNELS) && (32'(in_pos) < INPUT_LENGTH);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    win_hit = '0;
    for (int o = 0; o < OUTPUT_LENGTH; o++) begin
      win_hit[o] = (32'(in_pos) >= o * STRIDE) && (32'(in_pos) < o * STRIDE + POOL_SIZE);
    end
  end

  always_comb begin
    upd = '0;
    for (int c = 0; c < INPUT_CHANNELS; c++) begin
      for (int o = 0; o < OUTPUT_LENGTH; o++) begin
        upd[c*OUTPUT_LENGTH+o] = accept_hs && spike_ok && (32'(in_ch) == c) && win_hit[o];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (start) begin
      occ <= '0;
    end else begin
      occ <= occ | upd;
    end
  end

  // NOTE: the timestamp store is deliberately not reset; an entry is only read once its occupancy bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WIN; i++) begin
      if (upd[i] && (!occ[i] || in_ts > ts_mem[i])) begin
        ts_mem[i] <= in_ts;
      end
    end
  end

  assign cur_occ   = occ[scan_idx];
  assign scan_end  = (scan_idx == IDX_W'(NUM_WIN - 1));
  assign scan_step = enable && (state == EMIT) && (!cur_occ || m_axis_output_tready);

  // tlast marks the final occupied entry, so look ahead for any occupied entry past the cursor.
  always_comb begin
    later_occ = 1'b0;
    for (int i = 0; i < NUM_WIN; i++) begin
      if (i > int'(scan_idx) && occ[i]) begin
        later_occ = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx <= '0;
      scan_ch  <= '0;
      scan_pos <= '0;
    end else if (state != EMIT) begin
      scan_idx <= '0;
      scan_ch  <= '0;
      scan_pos <= '0;
    end else if (scan_step && !scan_end) begin
      scan_idx <= scan_idx + 1'b1;
      if (scan_pos == POS_W'(OUTPUT_LENGTH - 1)) begin
        scan_pos <= '0;
        scan_ch  <= scan_ch + 1'b1;
      end else begin
        scan_pos <= scan_pos + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next           = state;
    s_axis_input_tready  = 1'b0;
    m_axis_output_tvalid = 1'b0;
    m_axis_output_tdata  = '0;
    m_axis_output_tlast  = 1'b0;
    busy                 = 1'b0;
    layer_done           = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = ACCEPT;
      end
      ACCEPT: begin
        s_axis_input_tready = enable;
        busy                = 1'b1;
        if (accept_hs && s_axis_input_tlast) state_next = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (cur_occ) begin
          m_axis_output_tvalid = 1'b1;
          m_axis_output_tdata  = {16'(scan_pos), 8'(scan_ch), ts_mem[scan_idx]};
          m_axis_output_tlast  = !later_occ;
        end
        if (scan_step && scan_end) state_next = DONE;
      end
      DONE: begin
        layer_done = 1'b1;
        if (start) state_next = ACCEPT;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (start) begin
      drop_count <= '0;
    end else if (accept_hs && !spike_ok && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_snn_maxpool1d.sv
// Self-checking bench for snn_maxpool1d: single-spike vector table, hand-written frames
// and randomized frames checked against a window-level reference model.
module tb_snn_maxpool1d;

  localparam int IL = 16;
  localparam int IC = 4;
  localparam int PS = 2;
  localparam int ST = 2;
  localparam int OL = IL / ST;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        s_axis_input_tvalid;
  logic [31:0] s_axis_input_tdata;
  logic        s_axis_input_tlast;
  logic        s_axis_input_tready;
  logic        m_axis_output_tvalid;
  logic [31:0] m_axis_output_tdata;
  logic        m_axis_output_tlast;
  logic        m_axis_output_tready;
  logic        config_valid;
  logic [31:0] config_data;
  logic        busy;
  logic        layer_done;
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  snn_maxpool1d dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .enable               (enable),
    .s_axis_input_tvalid  (s_axis_input_tvalid),
    .s_axis_input_tdata   (s_axis_input_tdata),
    .s_axis_input_tlast   (s_axis_input_tlast),
    .s_axis_input_tready  (s_axis_input_tready),
    .m_axis_output_tvalid (m_axis_output_tvalid),
    .m_axis_output_tdata  (m_axis_output_tdata),
    .m_axis_output_tlast  (m_axis_output_tlast),
    .m_axis_output_tready (m_axis_output_tready),
    .config_valid         (config_valid),
    .config_data          (config_data),
    .busy                 (busy),
    .layer_done           (layer_done)
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
    ,
    .drop_count           (drop_count)
`endif
  );

  typedef struct {
    logic [7:0] ch;
    logic [7:0] pos;
    logic [7:0] ts;
    logic [7:0] flag;
  } spike_t;

  typedef struct {
    spike_t      sp;
    logic        has_beat;
    logic [31:0] word;
  } vec_t;

  int checks = 0;
  int errors = 0;

  spike_t      frame_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic        got_last_q[$];

  // Reference model: per-channel windows holding the latest timestamp seen.
  bit         m_occ [IC][OL];
  logic [7:0] m_ts  [IC][OL];
  int         m_drops;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
  endtask

  function automatic void model_clear();
    for (int c = 0; c < IC; c++) begin
      for (int o = 0; o < OL; o++) begin
        m_occ[c][o] = 1'b0;
        m_ts[c][o]  = 8'd0;
      end
    end
    m_drops = 0;
  endfunction

  function automatic void model_spike(input spike_t s);
    int ch  = int'(s.ch);
    int pos = int'(s.pos);
    if (s.flag[0] && ch < IC && pos < IL) begin
      for (int o = 0; o < OL; o++) begin
        if (pos >= o * ST && pos < o * ST + PS) begin
          if (!m_occ[ch][o] || s.ts > m_ts[ch][o]) m_ts[ch][o] = s.ts;
          m_occ[ch][o] = 1'b1;
        end
      end
    end else if (m_drops < 65535) begin
      m_drops++;
    end
  endfunction

  function automatic void model_expect();
    exp_q.delete();
    for (int c = 0; c < IC; c++) begin
      for (int o = 0; o < OL; o++) begin
        if (m_occ[c][o]) exp_q.push_back({16'(o), 8'(c), m_ts[c][o]});
      end
    end
  endfunction

  function automatic spike_t mk(input int ch, input int pos, input int ts, input int flag);
    spike_t s;
    s.ch   = 8'(ch);
    s.pos  = 8'(pos);
    s.ts   = 8'(ts);
    s.flag = 8'(flag);
    return s;
  endfunction

  task automatic do_start();
    @(negedge clk);
    config_valid = 1'b1;
    config_data  = 32'h1;
    @(negedge clk);
    config_valid = 1'b0;
    config_data  = 32'h0;
    model_clear();
  endtask

  task automatic send_spike(input spike_t s, input logic last);
    int n = 0;
    s_axis_input_tdata  = {s.pos, s.ch, s.ts, s.flag};
    s_axis_input_tlast  = last;
    s_axis_input_tvalid = 1'b1;
    while (!s_axis_input_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_axis_input_tready) fail_timeout("spike_accept");
    else @(posedge clk);
    @(negedge clk);
    s_axis_input_tvalid = 1'b0;
    s_axis_input_tlast  = 1'b0;
    s_axis_input_tdata  = 32'h0;
    model_spike(s);
  endtask

  task automatic send_frame();
    foreach (frame_q[i]) send_spike(frame_q[i], i == frame_q.size() - 1);
  endtask

  // mode 0: always ready, 1: ready every other cycle, 2: random ready.
  task automatic collect(input int mode, input string tag);
    int          n = 0;
    int          phase = 0;
    logic        rdy;
    logic        held_valid = 1'b0;
    logic [31:0] held = 32'h0;
    got_q.delete();
    got_last_q.delete();
    while (!layer_done && n < 2000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = phase[0];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      phase++;
      if (held_valid) begin
        check({tag, "_stall_valid"}, m_axis_output_tvalid, 1);
        check({tag, "_stall_data"}, m_axis_output_tdata, held);
      end
      m_axis_output_tready = rdy;
      if (m_axis_output_tvalid && rdy) begin
        got_q.push_back(m_axis_output_tdata);
        got_last_q.push_back(m_axis_output_tlast);
      end
      held_valid = m_axis_output_tvalid && !rdy;
      held       = m_axis_output_tdata;
      @(negedge clk);
      n++;
    end
    m_axis_output_tready = 1'b0;
    if (!layer_done) fail_timeout({tag, "_layer_done"});
  endtask

  task automatic compare(input string tag);
    int n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    check({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", tag, i), got_last_q[i], i == exp_q.size() - 1);
    end
    check({tag, "_done"}, layer_done, 1);
    check({tag, "_busy"}, busy, 0);
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
    check({tag, "_drops"}, drop_count, m_drops);
`endif
  endtask

  task automatic run_frame(input int mode, input string tag);
    send_frame();
    collect(mode, tag);
    compare(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[8];
    vecs[0] = '{mk(0, 0, 0, 1),     1'b1, 32'h0000_0000};
    vecs[1] = '{mk(3, 15, 255, 1),  1'b1, 32'h0007_03FF};
    vecs[2] = '{mk(2, 8, 5, 3),     1'b1, 32'h0004_0205};
    vecs[3] = '{mk(1, 7, 33, 1),    1'b1, 32'h0003_0121};
    vecs[4] = '{mk(4, 0, 1, 1),     1'b0, 32'h0};
    vecs[5] = '{mk(0, 16, 7, 1),    1'b0, 32'h0};
    vecs[6] = '{mk(0, 3, 9, 2),     1'b0, 32'h0};
    vecs[7] = '{mk(255, 255, 9, 1), 1'b0, 32'h0};

    rst_n = 1'b0;
    enable = 1'b1;
    s_axis_input_tvalid = 1'b0;
    s_axis_input_tdata = 32'h0;
    s_axis_input_tlast = 1'b0;
    m_axis_output_tready = 1'b0;
    config_valid = 1'b0;
    config_data = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_input_tready, 0);
    check("rst_tvalid", m_axis_output_tvalid, 0);
    check("rst_tdata", m_axis_output_tdata, 0);
    check("rst_tlast", m_axis_output_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", layer_done, 0);
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
    check("rst_drops", drop_count, 0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_tready", s_axis_input_tready, 0);
    check("idle_busy", busy, 0);

    // Single-spike frames from the vector table.
    for (int v = 0; v < 8; v++) begin
      do_start();
      check($sformatf("vec%0d_busy", v), busy, 1);
      check($sformatf("vec%0d_done_clr", v), layer_done, 0);
      frame_q.delete();
      frame_q.push_back(vecs[v].sp);
      send_frame();
      exp_q.delete();
      if (vecs[v].has_beat) exp_q.push_back(vecs[v].word);
      collect(0, $sformatf("vec%0d", v));
      compare($sformatf("vec%0d", v));
    end

    // Scenario 1
    do_start();
    frame_q.delete();
    frame_q.push_back(mk(0, 0, 100, 1));
    frame_q.push_back(mk(0, 1, 200, 1));
    exp_q.delete();
    exp_q.push_back(32'h0000_00C8);
    run_frame(0, "s1");

    // Scenario 2 and its back-pressured repeat (scenario 5)
    for (int rep = 0; rep < 2; rep++) begin
      do_start();
      frame_q.delete();
      frame_q.push_back(mk(0, 0, 100, 1));
      frame_q.push_back(mk(0, 2, 150, 1));
      frame_q.push_back(mk(0, 4, 200, 1));
      frame_q.push_back(mk(1, 1, 120, 1));
      frame_q.push_back(mk(1, 3, 180, 1));
      frame_q.push_back(mk(1, 5, 220, 1));
      exp_q.delete();
      exp_q.push_back(32'h0000_0064);
      exp_q.push_back(32'h0001_0096);
      exp_q.push_back(32'h0002_00C8);
      exp_q.push_back(32'h0000_0178);
      exp_q.push_back(32'h0001_01B4);
      exp_q.push_back(32'h0002_01DC);
      run_frame(rep == 0 ? 0 : 1, rep == 0 ? "s2" : "s5");
    end

    // Scenario 3
    do_start();
    frame_q.delete();
    for (int i = 0; i < 15; i++) frame_q.push_back(mk(0, i, i * 10 + 100, 1));
    frame_q.push_back(mk(0, 15, 255, 1));
    exp_q.delete();
    for (int o = 0; o < 7; o++) exp_q.push_back({16'(o), 8'h00, 8'((2 * o + 1) * 10 + 100)});
    exp_q.push_back(32'h0007_00FF);
    run_frame(0, "s3");

    // Scenario 4
    do_start();
    frame_q.delete();
    for (int c = 0; c < 4; c++) begin
      frame_q.push_back(mk(c, 0, 50 + 20 * c, 1));
      frame_q.push_back(mk(c, 1, 60 + 20 * c, 1));
    end
    frame_q.push_back(mk(0, 2, 100, 1));
    exp_q.delete();
    exp_q.push_back(32'h0000_003C);
    exp_q.push_back(32'h0001_0064);
    exp_q.push_back(32'h0000_0150);
    exp_q.push_back(32'h0000_0264);
    exp_q.push_back(32'h0000_0378);
    run_frame(2, "s4");

    // Scenario 6: every spike dropped
    do_start();
    frame_q.delete();
    frame_q.push_back(mk(7, 0, 10, 1));
    frame_q.push_back(mk(0, 20, 20, 1));
    exp_q.delete();
    run_frame(0, "s6");
`ifdef SNN_MAXPOOL1D_DROP_CNT_EN
    check("s6_drops_two", drop_count, 2);
`endif

    // A start request while accepting must not clear the collected windows.
    do_start();
    send_spike(mk(1, 4, 9, 1), 1'b0);
    config_valid = 1'b1;
    config_data  = 32'h1;
    @(negedge clk);
    config_valid = 1'b0;
    config_data  = 32'h0;
    send_spike(mk(0, 1, 200, 1), 1'b1);
    exp_q.delete();
    exp_q.push_back(32'h0000_00C8);
    exp_q.push_back(32'h0002_0109);
    collect(0, "ign_start");
    compare("ign_start");

    // enable low while accepting: no handshake, state held.
    do_start();
    enable = 1'b0;
    s_axis_input_tdata  = {8'd9, 8'd2, 8'd77, 8'd1};
    s_axis_input_tlast  = 1'b1;
    s_axis_input_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("en_tready%0d", i), s_axis_input_tready, 0);
      check($sformatf("en_busy%0d", i), busy, 1);
    end
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_axis_input_tvalid = 1'b0;
    s_axis_input_tlast  = 1'b0;
    s_axis_input_tdata  = 32'h0;
    model_spike(mk(2, 9, 77, 1));
    exp_q.delete();
    exp_q.push_back(32'h0004_024D);
    collect(0, "en_accept");
    compare("en_accept");

    // enable low while scanning: the scan freezes before reaching the late entry.
    do_start();
    send_spike(mk(3, 14, 42, 1), 1'b1);
    enable = 1'b0;
    m_axis_output_tready = 1'b1;
    repeat (40) @(negedge clk);
    check("en_scan_done", layer_done, 0);
    check("en_scan_busy", busy, 1);
    check("en_scan_valid", m_axis_output_tvalid, 0);
    m_axis_output_tready = 1'b0;
    enable = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0007_032A);
    collect(0, "en_scan");
    compare("en_scan");

    // Randomized frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(1, 24);
      do_start();
      frame_q.delete();
      for (int i = 0; i < n; i++) begin
        spike_t s;
        s = mk($urandom_range(0, 5), $urandom_range(0, 19), $urandom_range(0, 255), $urandom_range(0, 255));
        s.flag[0] = ($urandom_range(0, 9) < 8);
        frame_q.push_back(s);
      end
      send_frame();
      model_expect();
      collect(2, $sformatf("rnd%0d", f));
      compare($sformatf("rnd%0d", f));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
